glitc_prog_ctrl: RTL and testbench
==================================

# glitc_prog_ctrl

Per-GLITC configuration sequencer for the four GLITC FPGAs on the TISC. It drives PROGRAM_B and INIT_B for each GLITC independently, watches INIT_B and DONE, and produces the `gready` vector that tells the GLITCBUS master whether each GLITC is in configuration mode or GLITCBUS mode. It sits in the TISC register space: software issues per-GLITC program commands, then streams the bitstream through the GLITCBUS master while `gready` is low.

## Interface
Parameters:
- PROG_CYCLES, 64: clocks PROGRAM_B is held low (≥500 ns at 33 MHz).
- INIT_HOLD_CYCLES, 32: clocks INIT_B stays driven low after PROGRAM_B releases.
- TIMEOUT_BITS, 24: width of each channel timeout counter; a timeout fires when the counter reaches all-ones.

Ports (clk/reset first). One clock `clk_i`; reset is asynchronous and active-low (`rst_n_i`).
- clk_i  in  1  system clock, same clock as the GLITCBUS master.
- rst_n_i  in  1  asynchronous active-low reset.
- prog_cmd_i  in  4  one-cycle pulse per GLITC: start or restart the program sequence.
- done_i  in  4  raw DONE pins (asynchronous).
- init_b_i  in  4  raw INIT_B pin readback (asynchronous).
- program_b_o  out  4  PROGRAM_B drive (low = program).
- init_b_drive_o  out  4  1 = actively pull INIT_B low; 0 = release (external pull-up).
- gready_o  out  4  1 = GLITC configured; to the GLITCBUS master's gready input.
- state_o  out  12  3-bit state code per GLITC, bits [3n+2:3n].
- err_o  out  4  sticky per-GLITC error flag.

## Operation
- Four identical, independent channel FSMs. Each has its own TIMEOUT_BITS counter and 2-flop synchronizers on done_i[n] and init_b_i[n]. All outputs are registered.
- State codes:
  - UNCONF=0
  - PROG=1
  - INIT_HOLD=2
  - WAIT_INIT=3
  - LOAD=4
  - READY=5
  - ERROR=6
- UNCONF: program_b=1, init_drive=0, gready=0.
  - Synced DONE=1 → READY (adopts a GLITC that is already configured).
  - prog_cmd → PROG.
- PROG: program_b=0, init_drive=1. After exactly PROG_CYCLES clocks → INIT_HOLD.
- INIT_HOLD: program_b=1, init_drive=1. After exactly INIT_HOLD_CYCLES clocks → WAIT_INIT.
- WAIT_INIT: init_drive=0.
  - Synced INIT_B=1 → LOAD.
  - Timeout → ERROR.
- LOAD: gready=0; software streams the bitstream now.
  - Synced DONE=1 → READY.
  - Synced INIT_B=0 (CRC error) → ERROR.
  - Timeout → ERROR.
- READY: gready=1.
  - Synced DONE=0 → UNCONF, and err is set (configuration lost).
- ERROR: program_b=1, init_drive=0, gready=0. Holds until prog_cmd.
- Global rules:
  - prog_cmd in any state → PROG, clears err[n], and zeroes the counter. prog_cmd has priority over every other transition in the same cycle.
  - The counter zeroes on every state entry and counts in PROG, INIT_HOLD, WAIT_INIT and LOAD. It saturates and never wraps.
  - err_o[n] is set on entry to ERROR and on DONE loss. It is cleared only by prog_cmd or reset.
- gready_o falls regardless of any GLITCBUS transaction in progress. Software must not issue prog_cmd while a GLITCBUS access to that GLITC is outstanding.

## Timing
- Reset values: program_b_o=4'hF, init_b_drive_o=0, gready_o=0, state_o=0 (all UNCONF), err_o=0, counters=0, synchronizers=0. Reset asserted mid-sequence releases PROGRAM_B and INIT_B immediately (asynchronously).
- prog_cmd at edge N: state=PROG, program_b_o=0 and init_b_drive_o=1 all visible after edge N.
- program_b_o stays low for exactly PROG_CYCLES clocks. init_b_drive_o stays high for PROG_CYCLES+INIT_HOLD_CYCLES clocks.
- Synchronizer latency is 2 clocks. A raw DONE rise in LOAD gives gready_o=1 three edges later. A DONE drop in READY gives gready_o=0 three edges later.
- Simultaneous prog_cmd on several channels: each channel sequences independently; no arbitration.
- A second prog_cmd during PROG restarts the PROG count from 0.

## Test plan
- Reset, then done_i=4'h0 → all channels in UNCONF, program_b_o=4'hF, gready_o=0, err_o=0. Then drive done_i[2]=1 → gready_o=4'b0100 three clocks later.
- prog_cmd_i=4'b0001, then init_b_i[0] rises 10 clocks after release, then done_i[0] rises → program_b_o[0] low for exactly 64 clocks, init drive high for exactly 96 clocks, state walks 1,2,3,4,5, gready_o[0]=1, err_o=0.
- During LOAD, pull init_b_i[1] low → state_o[5:3]=6, err_o[1]=1, gready_o[1]=0. Then prog_cmd_i[1] → err_o[1] clears and state=PROG.
- TIMEOUT_BITS=8, keep init_b_i[3]=0 → ERROR after 255 clocks in WAIT_INIT, err_o[3]=1.
- From READY, drop done_i[0] → UNCONF with err_o[0]=1. Separately, prog_cmd on all four channels at once → all four program_b_o bits fall on the same edge.
- Assert rst_n_i mid-PROG → program_b_o=1 and init_b_drive_o=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/glitc_prog_ctrl.sv
// glitc_prog_ctrl: per-GLITC configuration sequencer for the four GLITC FPGAs.
// Each GLITC has its own channel FSM. The FSM drives PROGRAM_B and INIT_B,
// watches the synchronized INIT_B and DONE pins, and reports via gready
// whether the GLITC is configured (GLITCBUS mode) or still configuring.
//
// Ports:
//   clk_i           system clock, shared with the GLITCBUS master
//   rst_n_i         asynchronous active-low reset
//   prog_cmd_i[4]   one-cycle pulse per GLITC: start/restart programming
//   done_i[4]       raw DONE pins (asynchronous)
//   init_b_i[4]     raw INIT_B readback (asynchronous)
//   program_b_o[4]  PROGRAM_B drive, low = program
//   init_b_drive_o  1 = pull INIT_B low, 0 = release
//   gready_o[4]     1 = GLITC configured
//   state_o[12]     3-bit state code per GLITC at [3n+2:3n]
//   err_o[4]        sticky per-GLITC error flag

// One channel: synchronizers, sequencing FSM, timeout counter, registered outputs.
module glitc_prog_chan #(
  parameter int PROG_CYCLES      = 64,
  parameter int INIT_HOLD_CYCLES = 32,
  parameter int TIMEOUT_BITS     = 24
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       prog_cmd_i,
  input  logic       done_i,
  input  logic       init_b_i,
  output logic       program_b_o,
  output logic       init_b_drive_o,
  output logic       gready_o,
  output logic [2:0] state_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    S_UNCONF    = 3'd0,
    S_PROG      = 3'd1,
    S_INIT_HOLD = 3'd2,
    S_WAIT_INIT = 3'd3,
    S_LOAD      = 3'd4,
    S_READY     = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  localparam logic [TIMEOUT_BITS-1:0] CNT_MAX   = '1;
  localparam logic [TIMEOUT_BITS-1:0] PROG_LAST = TIMEOUT_BITS'(PROG_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0] HOLD_LAST = TIMEOUT_BITS'(INIT_HOLD_CYCLES - 1);
  // Timeout takes effect on the edge where the counter would reach all-ones.
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST  = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_e                  st_q, st_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]              done_sync, init_sync;
  logic                    done_s, init_s, tmo;
  logic                    pb_d, drv_d, gr_d, err_d;

  assign done_s = done_sync[1];
  assign init_s = init_sync[1];
  assign tmo    = (cnt_q >= TMO_LAST);

  // State register, counter, synchronizers and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q           <= S_UNCONF;
      cnt_q          <= '0;
      done_sync      <= '0;
      init_sync      <= '0;
      program_b_o    <= 1'b1;
      init_b_drive_o <= 1'b0;
      gready_o       <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      st_q           <= st_d;
      cnt_q          <= cnt_d;
      done_sync      <= {done_sync[0], done_i};
      init_sync      <= {init_sync[0], init_b_i};
      program_b_o    <= pb_d;
      init_b_drive_o <= drv_d;
      gready_o       <= gr_d;
      err_o          <= err_d;
    end
  end

  // Next-state logic; prog_cmd overrides every other transition.
  always_comb begin
    st_d = st_q;
    if (prog_cmd_i) begin
      st_d = S_PROG;
    end else begin
      case (st_q)
        S_UNCONF:    if (done_s) st_d = S_READY;
        S_PROG:      if (cnt_q == PROG_LAST) st_d = S_INIT_HOLD;
        S_INIT_HOLD: if (cnt_q == HOLD_LAST) st_d = S_WAIT_INIT;
        S_WAIT_INIT: begin
          if (init_s)   st_d = S_LOAD;
          else if (tmo) st_d = S_ERROR;
        end
        S_LOAD: begin
          if (done_s)       st_d = S_READY;
          else if (!init_s) st_d = S_ERROR;  // CRC error reported on INIT_B
          else if (tmo)     st_d = S_ERROR;
        end
        S_READY:     if (!done_s) st_d = S_UNCONF;
        S_ERROR:     st_d = S_ERROR;
        default:     st_d = S_UNCONF;
      endcase
    end
  end

  // Output/counter logic, decoded from the next state so the registered
  // outputs line up with state_o.
  always_comb begin
    pb_d  = 1'b1;
    drv_d = 1'b0;
    gr_d  = 1'b0;
    case (st_d)
      S_PROG:      begin pb_d = 1'b0; drv_d = 1'b1; end
      S_INIT_HOLD: drv_d = 1'b1;
      S_READY:     gr_d  = 1'b1;
      default:     ;
    endcase

    if (prog_cmd_i)
      err_d = 1'b0;
    else
      err_d = err_o | ((st_d == S_ERROR) && (st_q != S_ERROR))
                    | ((st_q == S_READY) && (st_d == S_UNCONF));

    cnt_d = cnt_q;
    if (prog_cmd_i || (st_d != st_q))
      cnt_d = '0;
    else if ((st_q inside {S_PROG, S_INIT_HOLD, S_WAIT_INIT, S_LOAD}) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  assign state_o = st_q;

endmodule

module glitc_prog_ctrl #(
  parameter int PROG_CYCLES      = 64,
  parameter int INIT_HOLD_CYCLES = 32,
  parameter int TIMEOUT_BITS     = 24
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  prog_cmd_i,
  input  logic [3:0]  done_i,
  input  logic [3:0]  init_b_i,
  output logic [3:0]  program_b_o,
  output logic [3:0]  init_b_drive_o,
  output logic [3:0]  gready_o,
  output logic [11:0] state_o,
  output logic [3:0]  err_o
);

  localparam int NUM_LANES = 4;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_chan
    glitc_prog_chan #(
      .PROG_CYCLES      (PROG_CYCLES),
      .INIT_HOLD_CYCLES (INIT_HOLD_CYCLES),
      .TIMEOUT_BITS     (TIMEOUT_BITS)
    ) u_chan (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .prog_cmd_i     (prog_cmd_i[g]),
      .done_i         (done_i[g]),
      .init_b_i       (init_b_i[g]),
      .program_b_o    (program_b_o[g]),
      .init_b_drive_o (init_b_drive_o[g]),
      .gready_o       (gready_o[g]),
      .state_o        (state_o[3*g +: 3]),
      .err_o          (err_o[g])
    );
  end

endmodule

// File: tb/tb_glitc_prog_ctrl.sv
// Bench for glitc_prog_ctrl. Channel behaviour is predicted from a timeline:
// for each channel a scenario (start edge, INIT_B release delay, event delay,
// outcome) gives the expected state as a function of the edge index, and the
// pin-level outputs follow from the per-state output table.
module tb_glitc_prog_ctrl;

  localparam int PC = 64;
  localparam int HC = 32;
  localparam int TB = 8;
  localparam int TMO = (1 << TB) - 1;  // clocks in WAIT_INIT before ERROR

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  prog_cmd, done, init_b;
  logic [3:0]  program_b, init_drv, gready, err;
  logic [11:0] state;

  int checks = 0;
  int failures = 0;

  // Scenario per channel: start edge, INIT_B delay, event delay, kind
  // (0 = configures, 1 = CRC error in LOAD, 2 = INIT_B never releases).
  int sc_s[4], sc_di[4], sc_dd[4], sc_k[4];

  glitc_prog_ctrl #(.PROG_CYCLES(PC), .INIT_HOLD_CYCLES(HC), .TIMEOUT_BITS(TB)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .prog_cmd_i     (prog_cmd),
    .done_i         (done),
    .init_b_i       (init_b),
    .program_b_o    (program_b),
    .init_b_drive_o (init_drv),
    .gready_o       (gready),
    .state_o        (state),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    prog_cmd = '0; done = '0; init_b = '0;
    step(); step();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_program_b", 32'(program_b), 32'hF);
    chk("rst_init_drv", 32'(init_drv), 32'h0);
    chk("rst_gready", 32'(gready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
  endtask

  // Expected state code of channel n after edge c of a scenario.
  function automatic int exp_state(int c, int n);
    int t, l;
    if (c < sc_s[n]) return 0;
    t = c - sc_s[n];
    if (t < PC) return 1;
    if (t < PC + HC) return 2;
    if (sc_k[n] == 2) return (t < PC + HC + TMO) ? 3 : 6;
    l = PC + HC + sc_di[n] + 2;       // 2-flop synchronizer, then the FSM edge
    if (t < l) return 3;
    if (t < l + sc_dd[n] + 2) return 4;
    return (sc_k[n] == 0) ? 5 : 6;
  endfunction

  task automatic run_scenario();
    int ncyc, t, l, st;
    logic [11:0] es;
    logic [3:0] epb, edrv, egr, eerr;
    do_reset();
    ncyc = 0;
    for (int n = 0; n < 4; n++)
      if (sc_s[n] + PC + HC + TMO + 4 > ncyc) ncyc = sc_s[n] + PC + HC + TMO + 4;
    for (int c = 0; c < ncyc; c++) begin
      for (int n = 0; n < 4; n++) begin
        t = c - sc_s[n];
        l = PC + HC + sc_di[n] + 2;
        prog_cmd[n] = (t == 0);
        init_b[n]   = (sc_k[n] != 2) && (t >= PC + HC + sc_di[n]) &&
                      !((sc_k[n] == 1) && (t >= l + sc_dd[n]));
        done[n]     = (sc_k[n] == 0) && (t >= l + sc_dd[n]);
      end
      step();
      for (int n = 0; n < 4; n++) begin
        st = exp_state(c, n);
        es[3*n +: 3] = 3'(st);
        epb[n]  = (st != 1);
        edrv[n] = (st == 1) || (st == 2);
        egr[n]  = (st == 5);
        eerr[n] = (st == 6);
      end
      chk("seq_state", 32'(state), 32'(es));
      chk("seq_program_b", 32'(program_b), 32'(epb));
      chk("seq_init_drv", 32'(init_drv), 32'(edrv));
      chk("seq_gready", 32'(gready), 32'(egr));
      chk("seq_err", 32'(err), 32'(eerr));
    end
    prog_cmd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    prog_cmd = '0; done = '0; init_b = '0;

    // Adopt an already-configured GLITC, then lose DONE.
    do_reset();
    done = 4'b0100;
    step(); step();
    chk("adopt_early", 32'(gready), 32'h0);
    step();
    chk("adopt_gready", 32'(gready), 32'h4);
    chk("adopt_state", 32'(state), 32'(12'd5 << 6));
    done = 4'b0000;
    step(); step();
    chk("loss_hold", 32'(gready), 32'h4);
    step();
    chk("loss_gready", 32'(gready), 32'h0);
    chk("loss_state", 32'(state), 32'h0);
    chk("loss_err", 32'(err), 32'h4);

    // All four start together: ok, CRC error, ok, WAIT_INIT timeout.
    sc_s  = '{0, 0, 0, 0};
    sc_di = '{10, 3, 0, 0};
    sc_dd = '{5, 4, 0, 0};
    sc_k  = '{0, 1, 0, 2};
    run_scenario();
    chk("a_final_state", 32'(state), 32'({3'd6, 3'd5, 3'd6, 3'd5}));

    // READY -> DONE loss on channel 0; prog_cmd on channel 1 clears its error.
    done[0] = 1'b0;
    step(); step();
    chk("drop_hold", 32'(state[2:0]), 32'd5);
    step();
    chk("drop_state", 32'(state[2:0]), 32'd0);
    chk("drop_gready", 32'(gready[0]), 32'd0);
    prog_cmd = 4'b0010;
    step();
    prog_cmd = 4'b0000;
    chk("reprog_state", 32'(state[5:3]), 32'd1);
    chk("reprog_err", 32'(err), 32'h9);
    chk("reprog_pb", 32'(program_b), 32'hD);

    // Randomized scenarios with staggered starts.
    for (int r = 0; r < 5; r++) begin
      for (int n = 0; n < 4; n++) begin
        sc_s[n]  = int'($urandom_range(0, 7));
        sc_di[n] = int'($urandom_range(0, 40));
        sc_dd[n] = int'($urandom_range(0, 40));
        sc_k[n]  = int'($urandom_range(0, 2));
      end
      run_scenario();
    end

    // Second prog_cmd during PROG restarts the count.
    do_reset();
    prog_cmd = 4'b0100;
    step();
    prog_cmd = 4'b0000;
    for (int i = 1; i < 30; i++) step();
    prog_cmd = 4'b0100;
    step();
    prog_cmd = 4'b0000;
    chk("restart_state", 32'(state[8:6]), 32'd1);
    for (int t = 1; t <= 100; t++) begin
      step();
      chk("restart_pb", 32'(program_b[2]), 32'(t >= PC));
      chk("restart_drv", 32'(init_drv[2]), 32'(t < PC + HC));
    end

    // Asynchronous reset in the middle of PROG.
    do_reset();
    prog_cmd = 4'hF;
    step();
    prog_cmd = 4'h0;
    chk("all_pb_low", 32'(program_b), 32'h0);
    chk("all_drv_high", 32'(init_drv), 32'hF);
    for (int i = 0; i < 10; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pb", 32'(program_b), 32'hF);
    chk("arst_drv", 32'(init_drv), 32'h0);
    chk("arst_state", 32'(state), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_after", 32'(program_b), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
